// File: rtl/led_trace_capture.sv
// led_trace_capture
// Records every change of a 32-bit LED word together with the cycle
// timestamp at which the change was seen. Records go into a small
// first-word-fall-through FIFO that a consumer drains with a valid/ready handshake.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..64)
//   STAMP_W   timestamp width; the stamp counter wraps at 2^STAMP_W
//
// Ports
//   CLK        single clock, rising edge
//   RESET      synchronous active-high reset
//   LEDS       LED word from the SOC, sampled every cycle
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_data   LED value of the head entry
//   out_stamp  timestamp of the head entry
//   level      number of entries held (0..DEPTH)
//   overflow   sticky: a change event was dropped because the FIFO was full
module led_trace_capture #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned STAMP_W = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                LEDS,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [STAMP_W-1:0]         out_stamp,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0]        FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]        LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0]      PTR_ONE   = AW'(1);
    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [31:0]        prev_leds_q, prev_leds_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               overflow_q, overflow_d;

    // Storage is deliberately left out of reset; level_q alone says what is live.
    logic [31:0]        data_mem  [DEPTH];
    logic [STAMP_W-1:0] stamp_mem [DEPTH];

    logic change;
    logic full;
    logic pop;
    logic push;

    always_comb begin
        change = (LEDS != prev_leds_q);
        full   = (level_q == FULL_LVL);
        pop    = (level_q != '0) && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push   = change && (!full || pop);
    end

    always_comb begin
        stamp_d     = stamp_q + STAMP_ONE;
        prev_leds_d = LEDS;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (change && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stamp_q     <= '0;
            prev_leds_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            stamp_q     <= stamp_d;
            prev_leds_q <= prev_leds_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    // The stamp stored is the pre-increment value seen at the sampling edge.
    always_ff @(posedge CLK) begin
        if (push && !RESET) begin
            data_mem[wr_ptr_q]  <= LEDS;
            stamp_mem[wr_ptr_q] <= stamp_q;
        end
    end

    always_comb begin
        out_valid = (level_q != '0);
        out_data  = data_mem[rd_ptr_q];
        out_stamp = stamp_mem[rd_ptr_q];
        level     = level_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_led_trace_capture.sv
// tb_led_trace_capture
// Directed stimulus for led_trace_capture. Expected records are queued when a
// change is driven; independent monitors compare the FIFO head at every negedge
// and retire the expectation when the consumer accepts it.
// Instance dut:  DEPTH=8, STAMP_W=16.  Instance dut4: DEPTH=8, STAMP_W=4 (stamp wrap).
module tb_led_trace_capture;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] LEDS;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_stamp;
    logic [3:0]  level;
    logic        overflow;

    logic        RESET4;
    logic [31:0] LEDS4;
    logic        ready4;
    logic        valid4;
    logic [31:0] data4;
    logic [3:0]  stamp4;
    logic [3:0]  level4;
    logic        ovf4;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q  [$];
    logic [35:0] exp4_q [$];

    // Independent model of the free-running stamp of dut.
    logic [15:0] tstamp = '0;

    always #5 CLK = ~CLK;

    led_trace_capture #(.DEPTH(8), .STAMP_W(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LEDS      (LEDS),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .level     (level),
        .overflow  (overflow)
    );

    led_trace_capture #(.DEPTH(8), .STAMP_W(4)) dut4 (
        .CLK       (CLK),
        .RESET     (RESET4),
        .LEDS      (LEDS4),
        .out_valid (valid4),
        .out_ready (ready4),
        .out_data  (data4),
        .out_stamp (stamp4),
        .level     (level4),
        .overflow  (ovf4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RESET) tstamp <= '0;
        else       tstamp <= tstamp + 16'd1;
    end

    always @(negedge CLK) begin
        if (!RESET && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", {16'd0, out_stamp, out_data}, 64'hDEAD);
            end else begin
                chk("head", {16'd0, out_stamp, out_data}, {16'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET4 && valid4) begin
            if (exp4_q.size() == 0) begin
                chk("head4_unexpected", {28'd0, stamp4, data4}, 64'hDEAD);
            end else begin
                chk("head4", {28'd0, stamp4, data4}, {28'd0, exp4_q[0]});
                if (ready4) void'(exp4_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        RESET     = 1'b1;
        step();
        exp_q.delete();
        RESET     = 1'b0;
    endtask

    task automatic drive(input logic [31:0] v, input bit expect_push);
        LEDS = v;
        if (expect_push) exp_q.push_back({tstamp, v});
    endtask

    bit saw_valid;

    initial begin
        RESET = 1'b1; LEDS = '0; out_ready = 1'b0;
        RESET4 = 1'b1; LEDS4 = '0; ready4 = 1'b1;
        step();
        RESET4 = 1'b0;

        // Reset state, then idle LEDS for 100 cycles.
        do_reset();
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        saw_valid = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (out_valid) saw_valid = 1;
        end
        chk("idle_valid_seen", saw_valid, 0);
        chk("idle_level", level, 0);
        chk("idle_overflow", overflow, 0);

        // Single event at stamp 5, consumer stalled.
        do_reset();
        steps(5);
        drive(32'h1, 1);
        step();
        chk("ev5_valid", out_valid, 1);
        chk("ev5_data", out_data, 32'h1);
        chk("ev5_stamp", out_stamp, 16'd5);
        chk("ev5_level", level, 1);
        step();
        chk("ev5_hold_data", out_data, 32'h1);
        chk("ev5_hold_stamp", out_stamp, 16'd5);
        out_ready = 1'b1;
        step();
        chk("ev5_drained", level, 0);
        chk("ev5_valid_low", out_valid, 0);
        step();
        chk("ready_on_empty", level, 0);

        // Nine changes into an 8-deep FIFO: ninth dropped.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(32'(i), i <= 8);
            step();
        end
        chk("fill_level", level, 8);
        chk("fill_overflow", overflow, 1);
        chk("fill_head", out_data, 32'h1);

        // Full FIFO, change with simultaneous pop: accepted at tail.
        drive(32'hA, 1);
        out_ready = 1'b1;
        step();
        chk("fullpop_level", level, 8);
        chk("fullpop_overflow", overflow, 1);
        chk("fullpop_head", out_data, 32'h2);
        steps(8);
        chk("drain_level", level, 0);
        chk("drain_valid", out_valid, 0);
        chk("drain_overflow_sticky", overflow, 1);

        // Push and pop in the same cycle with FIFO not full.
        drive(32'hB, 1);
        step();
        chk("pp_level1", level, 1);
        drive(32'hC, 1);
        step();
        chk("pp_level_same", level, 1);
        chk("pp_head", out_data, 32'hC);
        step();
        chk("pp_level0", level, 0);

        // Three entries queued, reset pulse discards them.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(32'(i), 1);
            step();
        end
        chk("q3_level", level, 3);
        do_reset();
        chk("rst2_level", level, 0);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_overflow", overflow, 0);
        drive(32'h55, 1);
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 32'h55);
        chk("post_rst_stamp", out_stamp, 16'd0);
        out_ready = 1'b1;
        step();
        chk("post_rst_drained", level, 0);

        // 4-bit stamp wrap on dut4: events at cycles 14 and 17.
        RESET4 = 1'b1;
        step();
        RESET4 = 1'b0;
        steps(14);
        LEDS4 = 32'hA;
        exp4_q.push_back({4'd14, 32'hA});
        step();
        steps(2);
        LEDS4 = 32'hB;
        exp4_q.push_back({4'd1, 32'hB});
        step();
        steps(2);
        chk("wrap_level", level4, 0);
        chk("wrap_overflow", ovf4, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("scoreboard4_empty", exp4_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
